bf_stdio_bridge: RTL
====================

// Module: bf_stdio_bridge
// PURPOSE
//   Buffered stdio bridge between the brainfuck core and the UART pair. A TX FIFO absorbs
//   core stdout bytes and drains them to uart_tx via a start/ready FSM. An RX FIFO collects
//   uart_rx bytes for the core's ',' instruction. Single clock: the core, bridge and UART
//   share clk. Replaces the unbuffered stdout_en -> uart_tx_start glue in the top level.
// PARAMETERS
//   DATA_WIDTH  8   character width, stdout/stdin/UART
//   TX_DEPTH    16  TX FIFO entries, power of 2, >=2
//   RX_DEPTH    16  RX FIFO entries, power of 2, >=2
//   EDGE_MODE   1   1: push one byte per rising edge of stdout_en (legacy level-held enable);
//                   0: push every cycle stdout_en=1 && stdout_stall=0 (valid/ready)
// PORTS
//   clk            in   1              system clock, all logic posedge
//   rstn           in   1              async active-low reset
//   stdout         in   DATA_WIDTH     byte from core
//   stdout_en      in   1              core output strobe (see EDGE_MODE)
//   stdout_stall   out  1              TX FIFO full; core must hold stdout/stdout_en
//   stdin          out  DATA_WIDTH     RX FIFO head byte
//   stdin_valid    out  1              RX FIFO not empty
//   stdin_ren      in   1              pop RX head this cycle (ignored when empty)
//   uart_tx_data   out  DATA_WIDTH     byte to uart_tx, stable from start until ready returns
//   uart_tx_start  out  1              one-cycle launch pulse to uart_tx
//   uart_tx_ready  in   1              uart_tx idle
//   uart_rx_data   in   DATA_WIDTH     received byte
//   uart_rx_valid  in   1              one-cycle pulse, uart_rx_data valid
//   tx_level       out  $clog2(TX_DEPTH)+1  TX FIFO occupancy
//   rx_overflow    out  1              sticky: RX byte dropped because RX FIFO full
// BEHAVIOUR
//   Reset (rstn=0, async): FIFOs empty, pointers 0, FSM IDLE, uart_tx_start=0,
//     uart_tx_data=0, stdout_stall=0, stdin_valid=0, stdin=0, tx_level=0, rx_overflow=0,
//     edge-detect history=0. Reset mid-transfer discards FIFO contents and any byte in flight.
//   FIFOs: circular, pointers one bit wider than index; full when MSBs differ and rest equal.
//     Push and pop in the same cycle on a full or empty FIFO are both honoured only where
//     legal: full+push+pop -> pop then push (level unchanged); empty+push+pop -> push only.
//   TX push: EDGE_MODE=1 -> stdout_en & ~stdout_en_q; an edge arriving while full is held
//     pending (one deep) and pushed on first non-full cycle; stall stays high meanwhile.
//     EDGE_MODE=0 -> stdout_en & ~full. stdout_stall = full | pending.
//   TX FSM:
//     IDLE:  FIFO non-empty && uart_tx_ready -> pop head into uart_tx_data, -> START.
//     START: uart_tx_start=1 for exactly this cycle -> BUSY.
//     BUSY:  wait uart_tx_ready=0 (uart_tx accepted) -> DRAIN.
//     DRAIN: wait uart_tx_ready=1 -> IDLE. Min 4 cycles per byte plus UART frame time.
//   RX: uart_rx_valid && !full -> push; uart_rx_valid && full -> drop, rx_overflow<=1 (sticky
//     until reset). Simultaneous stdin_ren on full FIFO frees a slot first: no drop.
//   stdin/stdin_valid: registered FIFO head, first-word fall-through; a pushed byte appears
//     the cycle after push; stdin_ren pops and presents next byte next cycle.
//   tx_level counts FIFO entries only (not the byte held in uart_tx_data).
//   All outputs registered except stdout_stall (combinational from full/pending flops).
// TESTING
//   1. Reset, EDGE_MODE=1, stdout_en high 5 cycles with 8'h41 -> exactly one byte 8'h41
//      on uart_tx_data, one uart_tx_start pulse, tx_level 1 -> 0.
//   2. Model uart_tx busy 100 cycles/byte; 20 edges of 8'h30..8'h43, TX_DEPTH=16 ->
//      stdout_stall asserts at full, all 20 bytes emitted in order, none duplicated.
//   3. EDGE_MODE=0, stdout_en held 3 cycles with ready free -> 3 bytes pushed back-to-back.
//   4. 17 uart_rx_valid pulses (8'h00..8'h10), no stdin_ren, RX_DEPTH=16 -> stdin_valid=1,
//      stdin=8'h00, byte 8'h10 dropped, rx_overflow=1; then 16 pops yield 8'h00..8'h0F.
//   5. RX full, uart_rx_valid and stdin_ren same cycle -> no drop, rx_overflow stays 0.
//   6. Assert rstn=0 in BUSY with 4 bytes queued -> next edge all outputs at reset values,
//      no further uart_tx_start after release until a new push.

Source files
------------

// File: rtl/bf_stdio_bridge.sv
// Buffered stdio bridge: core stdout -> TX FIFO -> uart_tx start/ready FSM,
// uart_rx -> RX FIFO -> registered first-word-fall-through head for the core's ','.

module bf_stdio_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic          full,
  output logic          push_ok,
  output logic          head_vld,
  output logic [DW-1:0] head,
  output logic [AW:0]   level
);
  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic          empty, pop_ok;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok   = pop && !empty;
  // a pop on a full FIFO frees the slot the same-cycle push lands in
  assign push_ok  = push && (!full || pop_ok);
  assign wr_ptr_n = wr_ptr + {{AW{1'b0}}, push_ok};
  assign rd_ptr_n = rd_ptr + {{AW{1'b0}}, pop_ok};

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // head is the next-cycle view of the queue; bypass when the only entry is being written now
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      head_vld <= 1'b0;
      head     <= '0;
      level    <= '0;
    end else begin
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      level    <= wr_ptr_n - rd_ptr_n;
      head_vld <= (wr_ptr_n != rd_ptr_n);
      if (wr_ptr_n == rd_ptr_n)                head <= '0;
      else if (push_ok && rd_ptr_n == wr_ptr)  head <= wdata;
      else                                     head <= mem[rd_ptr_n[AW-1:0]];
    end
  end
endmodule

module bf_stdio_bridge #(
  parameter int DATA_WIDTH = 8,
  parameter int TX_DEPTH   = 16,
  parameter int RX_DEPTH   = 16,
  parameter int EDGE_MODE  = 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [DATA_WIDTH-1:0]     stdout,
  input  logic                      stdout_en,
  output logic                      stdout_stall,
  output logic [DATA_WIDTH-1:0]     stdin,
  output logic                      stdin_valid,
  input  logic                      stdin_ren,
  output logic [DATA_WIDTH-1:0]     uart_tx_data,
  output logic                      uart_tx_start,
  input  logic                      uart_tx_ready,
  input  logic [DATA_WIDTH-1:0]     uart_rx_data,
  input  logic                      uart_rx_valid,
  output logic [$clog2(TX_DEPTH):0] tx_level,
  output logic                      rx_overflow
);
  typedef enum logic [1:0] {IDLE, START, BUSY, DRAIN} tx_state_e;

  tx_state_e                  state, state_n;
  logic                       en_q, pending, tx_req, tx_push, tx_pop, tx_full, tx_push_ok, tx_head_vld;
  logic [DATA_WIDTH-1:0]      tx_head;
  logic                       rx_full, rx_push_ok;
  logic [$clog2(RX_DEPTH):0]  rx_level;
  logic                       unused_fifo;

  assign unused_fifo = ^{rx_level, rx_full, tx_push_ok};

  // legacy cores hold stdout_en high for several cycles: one byte per rising edge,
  // and an edge that lands on a full FIFO waits in 'pending' with stdout held by the core
  assign tx_req       = (EDGE_MODE != 0) ? (pending || (stdout_en && !en_q)) : stdout_en;
  assign tx_push      = tx_req && !tx_full;
  assign stdout_stall = tx_full || pending;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en_q        <= 1'b0;
      pending     <= 1'b0;
      rx_overflow <= 1'b0;
    end else begin
      en_q        <= stdout_en;
      pending     <= (EDGE_MODE != 0) && tx_req && tx_full;
      rx_overflow <= rx_overflow || (uart_rx_valid && !rx_push_ok);
    end
  end

  bf_stdio_fifo #(.DW(DATA_WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rstn(rstn), .push(tx_push), .wdata(stdout), .pop(tx_pop),
    .full(tx_full), .push_ok(tx_push_ok), .head_vld(tx_head_vld), .head(tx_head), .level(tx_level)
  );

  bf_stdio_fifo #(.DW(DATA_WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rstn(rstn), .push(uart_rx_valid), .wdata(uart_rx_data), .pop(stdin_ren),
    .full(rx_full), .push_ok(rx_push_ok), .head_vld(stdin_valid), .head(stdin), .level(rx_level)
  );

  always_comb begin
    state_n = state;
    tx_pop  = 1'b0;
    case (state)
      IDLE:  if (tx_head_vld && uart_tx_ready) begin
               tx_pop  = 1'b1;
               state_n = START;
             end
      START: state_n = BUSY;
      BUSY:  if (!uart_tx_ready) state_n = DRAIN;
      DRAIN: if (uart_tx_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      uart_tx_start <= 1'b0;
      uart_tx_data  <= '0;
    end else begin
      state         <= state_n;
      uart_tx_start <= (state_n == START);
      if (tx_pop) uart_tx_data <= tx_head;
    end
  end
endmodule
